// File: rtl/truth_table_sweeper_if.sv
// Bundle between the lab test logic / networks under check and the truth-table sweeper.
// The sweeper takes the slave view; the stimulus side takes the master view.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 4
);
  logic                   start;
  logic                   abort;
  logic                   dut_f;
  logic                   ref_f;
  logic [N_IN-1:0]        vec;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_cnt;
  logic [N_IN-1:0]        first_err_vec;
  logic                   first_err_vld;
  logic [(2**N_IN)-1:0]   tt_dut;

  modport master (
    output start, abort, dut_f, ref_f,
    input  vec, busy, done, pass, err_cnt, first_err_vec, first_err_vld, tt_dut
  );

  modport slave (
    input  start, abort, dut_f, ref_f,
    output vec, busy, done, pass, err_cnt, first_err_vec, first_err_vld, tt_dut
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper comparing a gate network against a golden expression.
// Optional DUT truth-table capture is enabled with `define TT_SWEEP_LOG_EN.
module truth_table_sweeper #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam int unsigned NVec = 2**N_IN;
  localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSample,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CntW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]   first_err_vec_q, first_err_vec_d;
  logic              first_err_vld_q, first_err_vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mismatch;

`ifdef TT_SWEEP_LOG_EN
  logic [NVec-1:0]   tt_q, tt_d;
`endif

  assign mismatch = bus.dut_f ^ bus.ref_f;

  always_comb begin
    state_d         = state_q;
    vec_d           = vec_q;
    settle_cnt_d    = settle_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_vec_d = first_err_vec_q;
    first_err_vld_d = first_err_vld_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    pass_d          = pass_q;
`ifdef TT_SWEEP_LOG_EN
    tt_d            = tt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d         = StApply;
          vec_d           = '0;
          settle_cnt_d    = '0;
          err_cnt_d       = '0;
          first_err_vld_d = 1'b0;
          pass_d          = 1'b0;
          busy_d          = 1'b1;
`ifdef TT_SWEEP_LOG_EN
          tt_d            = '0;
`endif
        end
      end

      StApply: begin
        if (bus.abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (settle_cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      StSample: begin
        if (bus.abort) begin
          // Abort wins over the sample taken on the same edge; vec is left as-is.
          state_d = StIdle;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (!first_err_vld_q) begin
              first_err_vec_d = vec_q;
              first_err_vld_d = 1'b1;
            end
          end
`ifdef TT_SWEEP_LOG_EN
          tt_d[vec_q] = bus.dut_f;
`endif
          if (vec_q == '1) begin
            state_d = StDone;
          end else begin
            vec_d        = vec_q + 1'b1;
            settle_cnt_d = '0;
            state_d      = StApply;
          end
        end
      end

      StDone: begin
        // Sweep is complete, so abort no longer suppresses the done pulse.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_cnt_q == '0);
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      vec_q           <= '0;
      settle_cnt_q    <= '0;
      err_cnt_q       <= '0;
      first_err_vec_q <= '0;
      first_err_vld_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      vec_q           <= vec_d;
      settle_cnt_q    <= settle_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_vec_q <= first_err_vec_d;
      first_err_vld_q <= first_err_vld_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

`ifdef TT_SWEEP_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q <= '0;
    end else begin
      tt_q <= tt_d;
    end
  end

  assign bus.tt_dut = tt_q;
`else
  assign bus.tt_dut = '0;
`endif

  assign bus.vec           = vec_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_vec = first_err_vec_q;
  assign bus.first_err_vld = first_err_vld_q;

endmodule
